cordic_sincos_iter: RTL and testbench

- Full-circle, parametrised sine/cosine generator using iterative rotation-mode CORDIC.
- Performs one micro-rotation per clock, so area is shared across cycles.
- Successor to the combinational quarter-phase sine block. Adds full 0–360° phase, signed sin and cos outputs, configurable width and iteration count, and valid/ready handshakes on both sides.
- Sits between the phase accumulator (NCO) and the downstream mixer.

---
 rtl/cordic_sincos_iter.sv | 205 ++++++++++++++++++++
 tb/tb_cordic_sincos_iter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC producing signed sine and cosine over the full circle.
// One micro-rotation per clock; valid/ready handshakes on the phase input and the result output.
module cordic_sincos_iter #(
   parameter int WIDTH = 16,
   parameter int ITER  = 16,
   parameter int GUARD = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_phase,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sin,
   output logic [WIDTH-1:0] o_cos
);

   localparam int  DW   = WIDTH + GUARD + 1;
   localparam int  NW   = $clog2(ITER);
   localparam int  RW   = WIDTH + 2;
   localparam int  OMAX = (1 << (WIDTH - 1)) - 1;
   localparam int  HALF = (1 << GUARD) >> 1;
   localparam real PI   = 3.14159265358979323846;

   function automatic real real_sqrt(input real v);
      real r;
      r = v;
      for (int i = 0; i < 40; i++) begin
         r = 0.5 * (r + v / r);
      end
      return r;
   endfunction

   function automatic real real_atan(input real p);
      real sum;
      real term;
      real p2;
      sum  = 0.0;
      term = p;
      p2   = p * p;
      if (p >= 1.0) begin
         return PI / 4.0;
      end
      for (int k = 0; k < 60; k++) begin
         if ((k % 2) == 0) sum = sum + term / real'(2 * k + 1);
         else              sum = sum - term / real'(2 * k + 1);
         term = term * p2;
      end
      return sum;
   endfunction

   // Start vector pre-divided by the CORDIC gain so the final magnitude lands on full scale.
   function automatic int x_init_val();
      real k;
      real p;
      k = 1.0;
      p = 1.0;
      for (int i = 0; i < ITER; i++) begin
         k = k * real_sqrt(1.0 + p * p);
         p = p / 2.0;
      end
      return $rtoi(real'(OMAX) * (2.0 ** GUARD) / k + 0.5);
   endfunction

   function automatic logic [ITER*DW-1:0] atan_table();
      logic [ITER*DW-1:0] t;
      real                p;
      real                a;
      t = '0;
      p = 1.0;
      for (int n = 0; n < ITER; n++) begin
         a = real_atan(p) / (2.0 * PI) * (2.0 ** (WIDTH + GUARD));
         t[n*DW +: DW] = DW'($rtoi(a + 0.5));
         p = p / 2.0;
      end
      return t;
   endfunction

   localparam logic signed [DW-1:0]   X_INIT   = DW'(x_init_val());
   localparam logic [ITER*DW-1:0]     ATAN_TAB = atan_table();
   localparam logic signed [DW:0]     HALF_V   = (DW+1)'(HALF);
   localparam logic signed [RW-1:0]   R_MAX    = RW'(OMAX);
   localparam logic signed [RW-1:0]   R_MIN    = -R_MAX;

   // Drop the guard bits with round-half-up, then clamp to the symmetric full scale.
   function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [DW-1:0] v);
      logic signed [DW:0]   sum;
      logic signed [RW-1:0] r;
      sum = {v[DW-1], v} + HALF_V;
      r   = RW'(sum >>> GUARD);
      if (r > R_MAX)      return WIDTH'(OMAX);
      else if (r < R_MIN) return -WIDTH'(OMAX);
      else                return r[WIDTH-1:0];
   endfunction

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [NW-1:0]           n_q, n_d;
   logic [1:0]              quad_q, quad_d;
   logic signed [DW-1:0]    x_q, x_d;
   logic signed [DW-1:0]    y_q, y_d;
   logic signed [DW-1:0]    z_q, z_d;
   logic [WIDTH-1:0]        sin_q, sin_d;
   logic [WIDTH-1:0]        cos_q, cos_d;

   logic signed [DW-1:0]    x_sh, y_sh, atan_n;
   logic signed [DW-1:0]    x_rot, y_rot, z_rot;
   logic signed [WIDTH-1:0] s_r, c_r;

   always_comb begin
      x_sh   = x_q >>> n_q;
      y_sh   = y_q >>> n_q;
      atan_n = ATAN_TAB[int'(n_q)*DW +: DW];
      if (z_q[DW-1]) begin
         x_rot = x_q + y_sh;
         y_rot = y_q - x_sh;
         z_rot = z_q + atan_n;
      end else begin
         x_rot = x_q - y_sh;
         y_rot = y_q + x_sh;
         z_rot = z_q - atan_n;
      end
      s_r = round_sat(y_rot);
      c_r = round_sat(x_rot);
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      quad_d  = quad_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      sin_d   = sin_q;
      cos_d   = cos_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               quad_d  = i_phase[WIDTH-1 -: 2];
               z_d     = DW'(i_phase[WIDTH-3:0]) << GUARD;
               x_d     = X_INIT;
               y_d     = '0;
               n_d     = '0;
               state_d = ROTATE;
            end
         end
         ROTATE: begin
            x_d = x_rot;
            y_d = y_rot;
            z_d = z_rot;
            n_d = n_q + NW'(1);
            if (n_q == NW'(ITER - 1)) begin
               state_d = DONE;
               // Fold the first-quadrant result back out to the latched quadrant.
               case (quad_q)
                  2'd0:    begin sin_d = s_r;  cos_d = c_r;  end
                  2'd1:    begin sin_d = c_r;  cos_d = -s_r; end
                  2'd2:    begin sin_d = -s_r; cos_d = -c_r; end
                  default: begin sin_d = -c_r; cos_d = s_r;  end
               endcase
            end
         end
         DONE: begin
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         quad_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         quad_q  <= quad_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
      end
   end

   // Handshake: a phase is taken on an edge with i_valid && o_ready; a result leaves on an
   // edge with o_valid && i_ready. Both flags come from the state register alone.
   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == DONE);
   assign o_sin   = sin_q;
   assign o_cos   = cos_q;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Bench for cordic_sincos_iter: two instances (16/16 and 12/12) checked every cycle against
// a real-number sine/cosine model with a transaction-level view of the handshakes.
module tb_cordic_sincos_iter;

   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance a: WIDTH=16, ITER=16
   logic        rst_a = 1'b1, va = 1'b0, ra, ova, ira = 1'b1;
   logic [15:0] pa = '0, sa, ca;
   // instance b: WIDTH=12, ITER=12
   logic        rst_b = 1'b1, vb = 1'b0, rb, ovb, irb = 1'b1;
   logic [11:0] pb = '0, sb, cb;

   cordic_sincos_iter #(.WIDTH(16), .ITER(16), .GUARD(2)) dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_valid(va), .o_ready(ra), .i_phase(pa),
      .o_valid(ova), .i_ready(ira), .o_sin(sa), .o_cos(ca)
   );

   cordic_sincos_iter #(.WIDTH(12), .ITER(12), .GUARD(2)) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_valid(vb), .o_ready(rb), .i_phase(pb),
      .o_valid(ovb), .i_ready(irb), .o_sin(sb), .o_cos(cb)
   );

   int n_chk = 0;
   int n_fail = 0;

   // transaction model per instance: at most one phase in flight
   bit pend[2];
   int pend_ph[2];
   int due[2];
   bit armed[2];
   bit hold[2];
   int hold_s[2], hold_c[2];
   int last_s[2], last_c[2];
   int n_res[2];

   task automatic chk(input string name, input int act, input int req, input int tol);
      n_chk++;
      if (act > req + tol || act < req - tol) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
      end
   endtask

   function automatic int rnd(input real v);
      return $rtoi($floor(v + 0.5));
   endfunction

   function automatic void model(input int w, input int ph, output int es, output int ec);
      real a;
      real mx;
      a  = 2.0 * PI * real'(ph) / (2.0 ** w);
      mx = real'((1 << (w - 1)) - 1);
      es = rnd(mx * $sin(a));
      ec = rnd(mx * $cos(a));
   endfunction

   function automatic int rand_phase(input int w);
      int q;
      int corner;
      q = 1 << (w - 2);
      if ($urandom_range(0, 7) == 0) begin
         corner = $urandom_range(0, 6);
         case (corner)
            0: return 0;
            1: return q;
            2: return 2 * q;
            3: return 3 * q;
            4: return 4 * q - 1;
            5: return q - 1;
            default: return q + 1;
         endcase
      end
      return int'($urandom_range(0, (1 << w) - 1));
   endfunction

   // Sampled at the falling edge: inputs and outputs here are what the next rising edge sees.
   task automatic mon_step(input int id, input int w, input int iter, input bit rst,
                           input bit v, input bit rdy, input int ph, input bit ov,
                           input bit ir, input int s, input int c);
      string tag;
      bit    exp_ov;
      int    es, ec;
      tag = (id == 0) ? "a" : "b";
      if (rst) begin
         pend[id]   = 0;
         hold[id]   = 0;
         last_s[id] = 0;
         last_c[id] = 0;
         armed[id]  = 1;
         return;
      end
      if (!armed[id]) return;
      exp_ov = pend[id] && (cyc >= due[id]);
      chk($sformatf("%s.o_ready", tag), int'(rdy), int'(!pend[id]), 0);
      chk($sformatf("%s.o_valid", tag), int'(ov), int'(exp_ov), 0);
      if (!exp_ov) begin
         chk($sformatf("%s.sin_keep", tag), s, last_s[id], 0);
         chk($sformatf("%s.cos_keep", tag), c, last_c[id], 0);
      end else if (hold[id]) begin
         chk($sformatf("%s.sin_hold", tag), s, hold_s[id], 0);
         chk($sformatf("%s.cos_hold", tag), c, hold_c[id], 0);
      end
      if (exp_ov) begin
         if (ir) begin
            model(w, pend_ph[id], es, ec);
            chk($sformatf("%s.sin ph=%0h", tag, pend_ph[id]), s, es, 3);
            chk($sformatf("%s.cos ph=%0h", tag, pend_ph[id]), c, ec, 3);
            last_s[id] = s;
            last_c[id] = c;
            pend[id]   = 0;
            hold[id]   = 0;
            n_res[id]++;
         end else begin
            hold[id]   = 1;
            hold_s[id] = s;
            hold_c[id] = c;
         end
      end else if (v && !pend[id]) begin
         pend[id]    = 1;
         pend_ph[id] = ph;
         due[id]     = cyc + 1 + iter;
      end
   endtask

   always @(negedge clk) mon_step(0, 16, 16, rst_a, va, ra, int'(pa), ova, ira, $signed(sa), $signed(ca));
   always @(negedge clk) mon_step(1, 12, 12, rst_b, vb, rb, int'(pb), ovb, irb, $signed(sb), $signed(cb));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [15:0] ph);
      int t;
      va = 1'b1;
      pa = ph;
      t  = 0;
      @(negedge clk);
      while (!ra && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("a.accept_wait", int'(ra), 1, 0);
      tick();
      va = 1'b0;
      pa = 16'($urandom);
   endtask

   task automatic run_a();
      logic [15:0] dir_ph [7];
      int          t;
      dir_ph = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'h6000, 16'hFFFF};
      repeat (3) tick();
      rst_a = 1'b0;
      tick();
      foreach (dir_ph[i]) begin
         send_a(dir_ph[i]);
         repeat (20) tick();
      end
      // backpressure with a competing phase offered during ROTATE and DONE
      ira = 1'b0;
      send_a(16'h2000);
      va = 1'b1;
      pa = 16'h1234;
      t  = 0;
      @(negedge clk);
      while (!ova && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("a.bp_valid_wait", int'(ova), 1, 0);
      tick();
      repeat (10) begin
         pa = 16'($urandom);
         tick();
      end
      va  = 1'b0;
      ira = 1'b1;
      repeat (20) tick();
      // reset in the middle of a rotation, then a clean transaction
      send_a(16'h4000);
      repeat (4) tick();
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      send_a(16'h4000);
      repeat (20) tick();
      repeat (36000) begin
         va  = ($urandom_range(0, 1) == 1);
         pa  = 16'(rand_phase(16));
         ira = ($urandom_range(0, 3) != 0);
         tick();
      end
      va  = 1'b0;
      ira = 1'b1;
   endtask

   task automatic run_b();
      repeat (3) tick();
      rst_b = 1'b0;
      repeat (40000) begin
         vb  = ($urandom_range(0, 1) == 1);
         pb  = 12'(rand_phase(12));
         irb = ($urandom_range(0, 3) != 0);
         tick();
      end
      vb  = 1'b0;
      irb = 1'b1;
   endtask

   initial begin
      int es, ec;
      model(16, 'h4000, es, ec);
      chk("model.q1_sin", es, 32767, 0);
      chk("model.q1_cos", ec, 0, 0);
      model(16, 'h2000, es, ec);
      chk("model.45_sin", es, 23170, 0);
      chk("model.45_cos", ec, 23170, 0);
      model(12, 'h800, es, ec);
      chk("model.w12_180_sin", es, 0, 0);
      chk("model.w12_180_cos", ec, -2047, 0);
      model(16, 'hFFFF, es, ec);
      chk("model.wrap_sin", es, -3, 0);
      chk("model.wrap_cos", ec, 32767, 0);
      fork
         run_a();
         run_b();
      join
      repeat (40) tick();
      chk("a.result_count_min", int'(n_res[0] >= 1000), 1, 0);
      chk("b.result_count_min", int'(n_res[1] >= 1000), 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
